uart_tx_sequencer: RTL and testbench

//  UART transmit controller. Sequences one serial frame per accepted byte: start, data LSB-first, optional parity, stop.

---
 rtl/uart_tx_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// ----------------------------------------------------------------------------
// uart_tx_sequencer
//
// UART transmit controller. Each accepted byte is sent as one serial frame:
// start bit (0), W data bits LSB-first, optional even-parity bit, stop bit (1).
// Every bit is held for BAUD_DIV clock cycles. W is taken from bitWidth at
// accept time and clamped to 5..8.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY bit (even parity over the W
//                      latched data bits) is inserted between DATA and STOP.
//                      When undefined, no parity state or logic exists.
//
// Parameters:
//   BAUD_DIV   clk cycles per serial bit (>= 2)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   bitWidth   in   [3:0] requested data bits per frame (clamped 5..8)
//   tx_data    in   [7:0] byte to transmit
//   tx_valid   in   requester has a byte
//   tx_ready   out  controller idle; byte accepted when tx_valid is high
//   txd        out  serial line, idle high, registered
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the stop bit completes
//
// States:
//   state    | meaning
//   S_IDLE   | line idle (txd=1), ready for a byte
//   S_START  | start bit (txd=0)
//   S_DATA   | data bits, LSB first
//   S_PARITY | even parity bit (parity builds only)
//   S_STOP   | stop bit (txd=1)
// ----------------------------------------------------------------------------
module uart_tx_sequencer #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bitWidth,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int              CW      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitcnt;
    logic [2:0]      r_wlast;     // effective width minus one
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic            w_tick;
    logic            w_accept;
    logic [3:0]      w_width;

    assign w_tick   = r_busy & (r_cnt == CNT_MAX);
    assign w_accept = tx_valid & r_ready;

    always_comb begin
        w_width = bitWidth;
        if (bitWidth < 4'd5) begin
            w_width = 4'd5;
        end else if (bitWidth > 4'd8) begin
            w_width = 4'd8;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic       r_parity;
    logic [7:0] w_mask;
    logic       w_parity;

    // Parity is taken over the masked byte at accept, so later tx_data
    // changes cannot disturb it.
    assign w_mask   = 8'hFF >> (4'd8 - w_width);
    assign w_parity = ^(tx_data & w_mask);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_wlast  <= 3'd7;
            r_shift  <= '0;
            r_txd    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (r_state == S_IDLE || r_cnt == CNT_MAX) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_START;
                        r_shift  <= tx_data;
                        r_wlast  <= 3'(w_width - 4'd1);
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_txd    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= w_parity;
`endif
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        if (r_bitcnt == r_wlast) begin
                            r_bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state  <= S_PARITY;
                            r_txd    <= r_parity;
`else
                            r_state  <= S_STOP;
                            r_txd    <= 1'b1;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            r_shift  <= r_shift >> 1;
                            // txd is registered, so present the bit that
                            // will sit in shift[0] after this shift.
                            r_txd    <= r_shift[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = r_ready;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] bitWidth = 4'd8;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic       done;

    int nchecks = 0;
    int nerr = 0;
    int accepts = 0;

    uart_tx_sequencer #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .reset    (reset),
        .bitWidth (bitWidth),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) accepts <= accepts + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected txd in frame cycle k (1-based) for data d sent at width w.
    function automatic logic exp_bit(input logic [7:0] d, input int w, input int k);
        int  slot;
        logic par;
        slot = (k - 1) / BD;
        par = 1'b0;
        for (int i = 0; i < w; i++) par = par ^ d[i];
        if (slot == 0) return 1'b0;
        if (slot <= w) return d[slot-1];
        if (P == 1 && slot == w + 1) return par;
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nchecks++;
            if ({txd, tx_ready, busy, done} !== 4'b1100) begin
                nerr++;
                $display("FAIL reset_idle cycle %0d: {txd,ready,busy,done} got %b want 1100", i, {txd, tx_ready, busy, done});
            end
            step();
        end
    endtask

    task automatic test_basic();
        logic [10:0] seq;
        int nslots;
        int len;
        if (P == 1) begin
            seq = 11'b10010101010;
            nslots = 11;
        end else begin
            seq = 11'b01010101010;
            nslots = 10;
        end
        len = nslots * BD;
        tx_data  = 8'h55;
        bitWidth = 4'd8;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            nchecks++;
            if (txd !== seq[(k-1)/BD] || busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0) begin
                nerr++;
                $display("FAIL basic cycle %0d: txd/busy/done/ready got %b%b%b%b want %b100", k, txd, busy, done, tx_ready, seq[(k-1)/BD]);
            end
            step();
        end
        nchecks++;
        if ({done, tx_ready, busy, txd} !== 4'b1101) begin
            nerr++;
            $display("FAIL basic_done cycle %0d: {done,ready,busy,txd} got %b want 1101", len + 1, {done, tx_ready, busy, txd});
        end
        step();
        nchecks++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL basic_done_width: done got %b want 0", done);
        end
    endtask

    task automatic test_width_clamp();
        logic [3:0] bw_tab [4] = '{4'd3, 4'd12, 4'd5, 4'd7};
        logic [7:0] d_tab  [4] = '{8'hFF, 8'hA5, 8'h12, 8'h80};
        int         w_tab  [4] = '{5, 8, 5, 7};
        int         l_tab  [4] = '{28, 40, 28, 36};
        for (int t = 0; t < 4; t++) begin
            int len;
            len = l_tab[t] + P * BD;
            tx_data  = d_tab[t];
            bitWidth = bw_tab[t];
            tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            for (int k = 1; k <= len; k++) begin
                nchecks++;
                if (txd !== exp_bit(d_tab[t], w_tab[t], k) || done !== 1'b0) begin
                    nerr++;
                    $display("FAIL clamp bw=%0d cycle %0d: txd/done got %b%b want %b0", bw_tab[t], k, txd, done, exp_bit(d_tab[t], w_tab[t], k));
                end
                step();
            end
            nchecks++;
            if ({done, tx_ready, txd} !== 3'b111) begin
                nerr++;
                $display("FAIL clamp_len bw=%0d cycle %0d: {done,ready,txd} got %b want 111", bw_tab[t], len + 1, {done, tx_ready, txd});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int l1;
        int l2;
        a0 = accepts;
        l1 = (10 + P) * BD;
        l2 = (8 + P) * BD;
        tx_data  = 8'hA3;
        bitWidth = 4'd8;
        tx_valid = 1'b1;
        step();
        // New byte/width presented during frame 1; must only affect frame 2.
        tx_data  = 8'h0F;
        bitWidth = 4'd6;
        for (int k = 1; k <= l1; k++) begin
            nchecks++;
            if (txd !== exp_bit(8'hA3, 8, k) || done !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_f1 cycle %0d: txd/done got %b%b want %b0", k, txd, done, exp_bit(8'hA3, 8, k));
            end
            step();
        end
        nchecks++;
        if ({done, tx_ready, txd} !== 3'b111) begin
            nerr++;
            $display("FAIL b2b_gap cycle %0d: {done,ready,txd} got %b want 111", l1 + 1, {done, tx_ready, txd});
        end
        step();
        tx_valid = 1'b0;
        nchecks++;
        if ({done, txd, busy} !== 3'b001) begin
            nerr++;
            $display("FAIL b2b_start2: {done,txd,busy} got %b want 001", {done, txd, busy});
        end
        for (int k = 1; k <= l2; k++) begin
            nchecks++;
            if (txd !== exp_bit(8'h0F, 6, k) || done !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_f2 cycle %0d: txd/done got %b%b want %b0", k, txd, done, exp_bit(8'h0F, 6, k));
            end
            step();
        end
        nchecks++;
        if ({done, tx_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL b2b_done2: {done,ready} got %b want 11", {done, tx_ready});
        end
        step();
        nchecks++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_done2_width: done got %b want 0", done);
        end
        step();
        step();
        nchecks++;
        if (accepts - a0 !== 2) begin
            nerr++;
            $display("FAIL b2b_accepts: got %0d want 2", accepts - a0);
        end
    endtask

    task automatic test_mid_reset();
        int len;
        tx_data  = 8'h3C;
        bitWidth = 4'd8;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        // Data bit 3 occupies cycles 17..20 at BAUD_DIV=4.
        for (int k = 1; k <= 18; k++) begin
            nchecks++;
            if (txd !== exp_bit(8'h3C, 8, k)) begin
                nerr++;
                $display("FAIL midrst_pre cycle %0d: txd got %b want %b", k, txd, exp_bit(8'h3C, 8, k));
            end
            if (k < 18) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nchecks++;
        if ({txd, busy, tx_ready, done} !== 4'b1010) begin
            nerr++;
            $display("FAIL midrst_after: {txd,busy,ready,done} got %b want 1010", {txd, busy, tx_ready, done});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            nchecks++;
            if ({txd, done} !== 2'b10) begin
                nerr++;
                $display("FAIL midrst_nodone %0d: {txd,done} got %b want 10", i, {txd, done});
            end
        end
        len = (8 + P) * BD;
        tx_data  = 8'hC6;
        bitWidth = 4'd6;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            nchecks++;
            if (txd !== exp_bit(8'hC6, 6, k) || done !== 1'b0) begin
                nerr++;
                $display("FAIL midrst_next cycle %0d: txd/done got %b%b want %b0", k, txd, done, exp_bit(8'hC6, 6, k));
            end
            step();
        end
        nchecks++;
        if ({done, tx_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL midrst_next_done: {done,ready} got %b want 11", {done, tx_ready});
        end
        step();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d_tab [2] = '{8'h07, 8'h03};
        logic       p_tab [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            tx_data  = d_tab[t];
            bitWidth = 4'd8;
            tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            for (int k = 1; k <= 44; k++) begin
                if (k > 36 && k <= 40) begin
                    nchecks++;
                    if (txd !== p_tab[t]) begin
                        nerr++;
                        $display("FAIL parity data=%h cycle %0d: txd got %b want %b", d_tab[t], k, txd, p_tab[t]);
                    end
                end
                if (k > 40) begin
                    nchecks++;
                    if (txd !== 1'b1 || done !== 1'b0) begin
                        nerr++;
                        $display("FAIL parity_stop data=%h cycle %0d: txd/done got %b%b want 10", d_tab[t], k, txd, done);
                    end
                end
                step();
            end
            nchecks++;
            if (done !== 1'b1) begin
                nerr++;
                $display("FAIL parity_len data=%h: done at cycle 45 got %b want 1", d_tab[t], done);
            end
            step();
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        step();
        test_width_clamp();
        test_back_to_back();
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
